axi4_lite_gpu_cmdq: RTL and testbench
=====================================

Name: axi4_lite_gpu_cmdq

Overview:
Second-generation AXI4-Lite control slave for the GPU.
- Writes: AW and W are accepted independently, posted into a parametrised command FIFO, and drained by the GPU command decoder through a valid/ready port.
- Reads: forwarded to the decoder over a request/acknowledge handshake, with timeout.
- Adds WSTRB, address range checking and an optional read-after-write fence.

Parameters:
- AXI_ADDRESS_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- REG_INDEX_WIDTH, 6, width of the word index passed to the decoder.
- REG_COUNT, 64, number of valid word registers; must be <= 2^REG_INDEX_WIDTH.
- CMDQ_DEPTH, 8, command FIFO depth; must be a power of two, >= 2.
- RD_TIMEOUT, 255, maximum cycles to wait for rd_ack before returning SLVERR.
- RAW_FENCE, 1, when 1 a read is not accepted until the command FIFO is empty.

Ports:
- s_axi_ctrl_aclk  in  1  clock.
- s_axi_ctrl_aresetn  in  1  reset; asynchronous, active-low.
- s_axi_ctrl_awaddr / awvalid / awready  in/in/out  AXI_ADDRESS_WIDTH/1/1  write address channel.
- s_axi_ctrl_wdata / wstrb / wvalid / wready  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel.
- s_axi_ctrl_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s_axi_ctrl_araddr / arvalid / arready  in/in/out  AXI_ADDRESS_WIDTH/1/1  read address channel.
- s_axi_ctrl_rdata / rresp / rvalid / rready  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel.
- cmd_valid / cmd_ready  out/in  1/1  command FIFO head handshake.
- cmd_index  out  REG_INDEX_WIDTH  register word index.
- cmd_data  out  AXI_DATA_WIDTH  write data.
- cmd_strb  out  AXI_DATA_WIDTH/8  byte strobes.
- rd_req  out  1  read request; level, held until rd_ack or timeout.
- rd_index  out  REG_INDEX_WIDTH  read word index.
- rd_ack  in  1  decoder read complete; single-cycle pulse.
- rd_data  in  AXI_DATA_WIDTH  read data, valid with rd_ack.
- rd_err  in  1  decoder error, valid with rd_ack.
- cmdq_level  out  clog2(CMDQ_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - While aresetn is low, asynchronously clear every output and register to 0: all ready and valid signals, bresp, rresp, rdata, cmd_*, rd_req, rd_index, cmdq_level.
  - Empty the FIFO and drop any holding registers, pending read or timeout count.
  - No state survives reset asserted mid-transaction.
- Word index: addr[ALSB +: REG_INDEX_WIDTH], where ALSB = log2(AXI_DATA_WIDTH/8). Lower address bits are ignored.
- Address is out of range (OOR) if the index >= REG_COUNT, or if any address bit above ALSB+REG_INDEX_WIDTH-1 is set.
- AW capture: awready = !aw_held. On awvalid && awready, latch the address and set aw_held.
- W capture: wready = !w_held. On wvalid && wready, latch data and strb and set w_held. AW and W may arrive in either order or in the same cycle.
- Commit: fires in the cycle where aw_held && w_held && !bvalid, and either the write is an error or level < CMDQ_DEPTH.
  - Error write (OOR, or wstrb == 0): nothing is pushed; bresp = SLVERR (2'b10).
  - Valid write: push {index, data, strb} to the FIFO; bresp = OKAY.
  - In both cases clear aw_held and w_held, and set bvalid on the next edge.
- Full FIFO: a valid write stalls in the holding registers. bvalid stays low and awready/wready stay low until a pop frees space.
- No same-cycle push-on-full: a push is not allowed when level == CMDQ_DEPTH, even if a pop occurs in the same cycle.
- B channel: bvalid and bresp hold until bready; they clear on the edge where bvalid && bready. The response is posted: it does not wait for decoder execution.
- FIFO:
  - cmd_valid = (level != 0); cmd_* present the head entry.
  - Pop on cmd_valid && cmd_ready.
  - Simultaneous push and pop leaves level unchanged.
  - Read and write pointers wrap modulo CMDQ_DEPTH.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready = 1 when RAW_FENCE == 0 or level == 0; otherwise 0.
  - On arvalid && arready, latch the index.
  - OOR read: go directly to R_RESP with rdata = 0 and rresp = SLVERR; rd_req is never raised.
  - In-range read: assert rd_req with rd_index, clear the timer, go to R_WAIT.
  - R_WAIT, on rd_ack: drop rd_req; rdata = rd_data; rresp = rd_err ? SLVERR : OKAY; go to R_RESP.
  - R_WAIT, on timer reaching RD_TIMEOUT without rd_ack: drop rd_req; rdata = 0; rresp = SLVERR; go to R_RESP.
  - rd_ack in the same cycle as the timeout: rd_ack wins.
  - R_RESP: rvalid = 1; rdata/rresp are stable. On rready, go to R_IDLE. Earliest arready after rready is the next cycle.
  - rd_ack while not in R_WAIT is ignored.
- Read and write paths are fully independent except for the RAW_FENCE rule.

Test Plan:
- Reset, then write index 3 = 0xDEADBEEF, strb 0xF: bvalid 1 cycle after the last AW/W handshake with bresp 00; cmd_valid with cmd_index 3, cmd_data 0xDEADBEEF; cmdq_level 1 then 0 after cmd_ready.
- W sent 5 cycles before AW, then the reverse order: both complete with identical cmd outputs; wready stays low between W capture and commit.
- cmd_ready held 0, 9 writes at CMDQ_DEPTH=8: writes 1-8 get OKAY and level reaches 8; write 9 gets no bvalid. Pulse cmd_ready once: level 8 -> 7 -> 8, and write 9 receives bvalid.
- Write to index 64 (REG_COUNT=64), and a write with wstrb 0: both get bresp 10 and cmdq_level is unchanged. Read of index 70: rresp 10, rdata 0, rd_req never asserted.
- Read with rd_ack after 4 cycles, rd_data 0x12345678, rd_err 0: rdata 0x12345678, rresp 00. Read with rd_ack withheld: rd_req drops after RD_TIMEOUT=255 cycles with rresp 10.
- RAW_FENCE=1, 2 queued commands with cmd_ready 0 and arvalid 1: arready stays 0 until level hits 0. Then assert aresetn low mid-read: rd_req, rvalid, bvalid and cmd_valid drop immediately with no clock edge.

Source files
------------

// File: rtl/axi4_lite_gpu_cmdq.sv
// AXI4-Lite control slave for the GPU. Writes are posted into a command FIFO
// that the decoder drains; reads are forwarded over rd_req/rd_ack with a timeout.
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for AR (held off by the fence while commands are queued)
//   R_WAIT | rd_req raised, waiting for rd_ack or timeout
//   R_RESP | rvalid raised, rdata/rresp held until rready
module axi4_lite_gpu_cmdq #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int REG_INDEX_WIDTH   = 6,
    parameter int REG_COUNT         = 64,
    parameter int CMDQ_DEPTH        = 8,
    parameter int RD_TIMEOUT        = 255,
    parameter int RAW_FENCE         = 1
) (
    input  logic                          s_axi_ctrl_aclk,
    input  logic                          s_axi_ctrl_aresetn,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_awaddr,
    input  logic                          s_axi_ctrl_awvalid,
    output logic                          s_axi_ctrl_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
    input  logic                          s_axi_ctrl_wvalid,
    output logic                          s_axi_ctrl_wready,
    output logic [1:0]                    s_axi_ctrl_bresp,
    output logic                          s_axi_ctrl_bvalid,
    input  logic                          s_axi_ctrl_bready,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_araddr,
    input  logic                          s_axi_ctrl_arvalid,
    output logic                          s_axi_ctrl_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
    output logic [1:0]                    s_axi_ctrl_rresp,
    output logic                          s_axi_ctrl_rvalid,
    input  logic                          s_axi_ctrl_rready,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [REG_INDEX_WIDTH-1:0]    cmd_index,
    output logic [AXI_DATA_WIDTH-1:0]     cmd_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   cmd_strb,
    output logic                          rd_req,
    output logic [REG_INDEX_WIDTH-1:0]    rd_index,
    input  logic                          rd_ack,
    input  logic [AXI_DATA_WIDTH-1:0]     rd_data,
    input  logic                          rd_err,
    output logic [$clog2(CMDQ_DEPTH):0]   cmdq_level
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int ALSB   = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(CMDQ_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [AXI_ADDRESS_WIDTH-1:0] REG_LIMIT = AXI_ADDRESS_WIDTH'(REG_COUNT);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(CMDQ_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic clk, rst_n;
    assign clk   = s_axi_ctrl_aclk;
    assign rst_n = s_axi_ctrl_aresetn;

    logic                       aw_held_q, aw_oor_q, w_held_q, bvalid_q;
    logic [REG_INDEX_WIDTH-1:0] aw_idx_q;
    logic [AXI_DATA_WIDTH-1:0]  w_data_q;
    logic [STRB_W-1:0]          w_strb_q;
    logic [1:0]                 bresp_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]           level_q;
    logic                       aw_fire, w_fire, wr_err, commit, push, pop;

    logic [REG_INDEX_WIDTH-1:0] q_idx  [CMDQ_DEPTH];
    logic [AXI_DATA_WIDTH-1:0]  q_data [CMDQ_DEPTH];
    logic [STRB_W-1:0]          q_strb [CMDQ_DEPTH];

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign s_axi_ctrl_awready = rst_n & ~aw_held_q;
    assign s_axi_ctrl_wready  = rst_n & ~w_held_q;
    assign aw_fire = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
    assign w_fire  = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
    assign wr_err  = aw_oor_q | (w_strb_q == '0);
    assign commit  = aw_held_q & w_held_q & ~bvalid_q & (wr_err | (level_q != LVL_FULL));
    assign push    = commit & ~wr_err;
    assign pop     = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            aw_oor_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= s_axi_ctrl_awaddr[ALSB +: REG_INDEX_WIDTH];
                aw_oor_q  <= (s_axi_ctrl_awaddr >> ALSB) >= REG_LIMIT;
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axi_ctrl_wdata;
                w_strb_q <= s_axi_ctrl_wstrb;
            end else if (commit) begin
                w_held_q <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axi_ctrl_bready) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr_q]  <= aw_idx_q;
            q_data[wr_ptr_q] <= w_data_q;
            q_strb[wr_ptr_q] <= w_strb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    assign s_axi_ctrl_bvalid = bvalid_q;
    assign s_axi_ctrl_bresp  = bresp_q;
    assign cmdq_level        = level_q;
    assign cmd_valid         = (level_q != '0);
    assign cmd_index         = cmd_valid ? q_idx[rd_ptr_q]  : '0;
    assign cmd_data          = cmd_valid ? q_data[rd_ptr_q] : '0;
    assign cmd_strb          = cmd_valid ? q_strb[rd_ptr_q] : '0;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;

    rd_state_e                  state_q, state_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [REG_INDEX_WIDTH-1:0] rd_index_q, rd_index_d;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       ar_fire, ar_oor;

    assign s_axi_ctrl_arready = rst_n & (state_q == R_IDLE) & ((RAW_FENCE == 0) | (level_q == '0));
    assign ar_fire = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
    assign ar_oor  = (s_axi_ctrl_araddr >> ALSB) >= REG_LIMIT;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        rd_index_d = rd_index_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_index_d = s_axi_ctrl_araddr[ALSB +: REG_INDEX_WIDTH];
                    if (ar_oor) begin
                        state_d = R_RESP;
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        state_d = R_WAIT;
                        tmr_d   = TMR_LOAD;
                    end
                end
            end
            R_WAIT: begin
                // rd_ack takes priority over a timeout landing in the same cycle.
                if (rd_ack) begin
                    state_d = R_RESP;
                    rdata_d = rd_data;
                    rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
                end else if (tmr_q == '0) begin
                    state_d = R_RESP;
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            R_RESP: begin
                if (s_axi_ctrl_rready) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= R_IDLE;
            tmr_q      <= '0;
            rd_index_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            rd_index_q <= rd_index_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign rd_req            = (state_q == R_WAIT);
    assign rd_index          = rd_index_q;
    assign s_axi_ctrl_rvalid = (state_q == R_RESP);
    assign s_axi_ctrl_rdata  = rdata_q;
    assign s_axi_ctrl_rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_gpu_cmdq.sv
// Directed bench for axi4_lite_gpu_cmdq: posted writes, FIFO full/stall,
// error responses, read ack/timeout, read-after-write fence and async reset.
module tb_axi4_lite_gpu_cmdq;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata, cmd_data, rd_data;
    logic [3:0]  wstrb, cmd_strb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        cmd_valid, cmd_ready, rd_req, rd_ack, rd_err;
    logic [5:0]  cmd_index, rd_index;
    logic [3:0]  cmdq_level;

    int checks = 0;
    int failures = 0;

    logic [1:0]  resp, rr;
    logic [31:0] rd;
    bit          got, ok;
    int          rq;

    always #5 clk = ~clk;

    axi4_lite_gpu_cmdq #(
        .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .REG_INDEX_WIDTH(6),
        .REG_COUNT(64), .CMDQ_DEPTH(8), .RD_TIMEOUT(TO), .RAW_FENCE(1)
    ) dut (
        .s_axi_ctrl_aclk(clk), .s_axi_ctrl_aresetn(aresetn),
        .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
        .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_wvalid(wvalid),
        .s_axi_ctrl_wready(wready),
        .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
        .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
        .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp), .s_axi_ctrl_rvalid(rvalid),
        .s_axi_ctrl_rready(rready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rd_req(rd_req), .rd_index(rd_index), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_err(rd_err), .cmdq_level(cmdq_level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] r, output bit got_b);
        int n;
        bit aw_hs, w_hs;
        got_b = 1'b0;
        r = 2'b11;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!got_b && n < 20) begin
            @(negedge clk);
            if (bvalid) begin got_b = 1'b1; r = bresp; end
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ack_dly = number of rd_req cycles before rd_ack is driven; -1 never acks.
    task automatic do_read(input logic [31:0] addr, input int ack_dly, input logic [31:0] ad,
                           input logic ae, output logic [31:0] d, output logic [1:0] rs,
                           output int req_cycles, output bit done);
        int n;
        done = 1'b0; req_cycles = 0; d = '0; rs = 2'b11;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (arready) break;
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            if (rvalid) begin d = rdata; rs = rresp; done = 1'b1; end
            else if (rd_req) req_cycles++;
            @(posedge clk); #1;
            rd_ack = 1'b0;
            if (!done && ack_dly >= 0 && req_cycles == ack_dly) begin
                rd_ack = 1'b1; rd_data = ad; rd_err = ae;
            end
            n++;
        end
        rd_ack = 1'b0;
        rready = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(posedge clk); #1 cmd_ready = 1'b0;
    endtask

    task automatic split_write(input bit w_first);
        @(posedge clk); #1;
        if (w_first) begin wdata = 32'hA5A5_0001; wstrb = 4'b0110; wvalid = 1'b1; end
        else begin awaddr = 32'h28; awvalid = 1'b1; end
        @(negedge clk);
        chk("first_ready", w_first ? wready : awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("held_ready_low", w_first ? wready : awready, 0);
            chk("no_early_b", bvalid, 0);
        end
        @(posedge clk); #1;
        if (w_first) begin awaddr = 32'h28; awvalid = 1'b1; end
        else begin wdata = 32'hA5A5_0001; wstrb = 4'b0110; wvalid = 1'b1; end
        @(negedge clk);
        chk("second_ready", w_first ? awready : wready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("split_wready_pre", wready, 0);
        chk("split_b_pre", bvalid, 0);
        @(negedge clk);
        chk("split_bvalid", bvalid, 1);
        chk("split_bresp", bresp, 2'b00);
        chk("split_idx", cmd_index, 10);
        chk("split_data", cmd_data, 32'hA5A5_0001);
        chk("split_strb", cmd_strb, 4'b0110);
        chk("split_level", cmdq_level, 1);
        pop_one();
        @(negedge clk);
        chk("split_drained", cmdq_level, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; cmd_ready = 0; rd_ack = 0; rd_data = '0; rd_err = 0;
        #3;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_level", cmdq_level, 0);
        chk("rst_rd_req", rd_req, 0);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);

        // Basic write, B held until bready, then pop.
        @(posedge clk); #1;
        awaddr = 32'h0C; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        chk("w1_awready", awready, 1);
        chk("w1_wready", wready, 1);
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("w1_b_not_yet", bvalid, 0);
        chk("w1_awready_held", awready, 0);
        @(negedge clk);
        chk("w1_bvalid", bvalid, 1);
        chk("w1_bresp", bresp, 2'b00);
        chk("w1_cmd_valid", cmd_valid, 1);
        chk("w1_cmd_index", cmd_index, 3);
        chk("w1_cmd_data", cmd_data, 32'hDEAD_BEEF);
        chk("w1_cmd_strb", cmd_strb, 4'hF);
        chk("w1_level", cmdq_level, 1);
        @(posedge clk); #1 bready = 1;
        @(negedge clk);
        chk("w1_b_hold", bvalid, 1);
        @(posedge clk); #1 bready = 0;
        @(negedge clk);
        chk("w1_b_clear", bvalid, 0);
        pop_one();
        @(negedge clk);
        chk("w1_level_pop", cmdq_level, 0);
        chk("w1_cmd_valid_pop", cmd_valid, 0);

        bready = 1;
        split_write(1'b1);
        split_write(1'b0);

        // Fill the FIFO, ninth write stalls until one pop.
        cmd_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            do_write(32'(i * 4), 32'h100 + 32'(i), 4'hF, resp, got);
            chk("fill_got_b", got, 1);
            chk("fill_bresp", resp, 2'b00);
        end
        chk("fill_level", cmdq_level, 8);
        do_write(32'd36, 32'h109, 4'hF, resp, got);
        chk("full_no_b", got, 0);
        chk("full_level", cmdq_level, 8);
        chk("full_awready", awready, 0);
        chk("full_wready", wready, 0);
        @(posedge clk); #1 cmd_ready = 1;
        @(negedge clk);
        chk("full_head", cmd_data, 32'h101);
        chk("full_level_pre", cmdq_level, 8);
        @(posedge clk); #1 cmd_ready = 0;
        @(negedge clk);
        chk("full_level_pop", cmdq_level, 7);
        chk("full_b_pending", bvalid, 0);
        @(negedge clk);
        chk("full_level_refill", cmdq_level, 8);
        chk("full_b_late", bvalid, 1);
        chk("full_bresp_late", bresp, 2'b00);
        for (int j = 2; j <= 9; j++) begin
            chk("drain_order", cmd_data, 32'h100 + 32'(j));
            pop_one();
            @(negedge clk);
        end
        chk("drain_level", cmdq_level, 0);

        // Error writes.
        do_write(32'h100, 32'h1, 4'hF, resp, got);
        chk("oor_w_got_b", got, 1);
        chk("oor_w_bresp", resp, 2'b10);
        chk("oor_w_level", cmdq_level, 0);
        do_write(32'h14, 32'h2, 4'h0, resp, got);
        chk("strb0_bresp", resp, 2'b10);
        chk("strb0_level", cmdq_level, 0);

        // Reads: ack, timeout, decoder error, out of range.
        do_read(32'h1C, 4, 32'h1234_5678, 1'b0, rd, rr, rq, ok);
        chk("rd_ack_ok", ok, 1);
        chk("rd_ack_data", rd, 32'h1234_5678);
        chk("rd_ack_resp", rr, 2'b00);
        chk("rd_ack_req_cycles", rq, 5);
        chk("rd_ack_index", rd_index, 7);
        do_read(32'h1C, -1, 32'h0, 1'b0, rd, rr, rq, ok);
        chk("rd_to_ok", ok, 1);
        chk("rd_to_data", rd, 32'h0);
        chk("rd_to_resp", rr, 2'b10);
        chk("rd_to_req_cycles", rq, TO);
        do_read(32'h20, 1, 32'hCAFE_0000, 1'b1, rd, rr, rq, ok);
        chk("rd_err_data", rd, 32'hCAFE_0000);
        chk("rd_err_resp", rr, 2'b10);
        chk("rd_err_req_cycles", rq, 2);
        do_read(32'h118, 3, 32'hFFFF_FFFF, 1'b0, rd, rr, rq, ok);
        chk("rd_oor_ok", ok, 1);
        chk("rd_oor_data", rd, 32'h0);
        chk("rd_oor_resp", rr, 2'b10);
        chk("rd_oor_no_req", rq, 0);

        // Read-after-write fence.
        do_write(32'h30, 32'hF00D_0001, 4'hF, resp, got);
        do_write(32'h34, 32'hF00D_0002, 4'hF, resp, got);
        chk("fence_level", cmdq_level, 2);
        @(posedge clk); #1 araddr = 32'h08; arvalid = 1; rready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("fence_arready_lvl2", arready, 0);
        end
        pop_one();
        @(negedge clk);
        chk("fence_level1", cmdq_level, 1);
        chk("fence_arready_lvl1", arready, 0);
        chk("fence_no_req", rd_req, 0);
        pop_one();
        @(negedge clk);
        chk("fence_level0", cmdq_level, 0);
        chk("fence_arready_open", arready, 1);
        @(posedge clk); #1 arvalid = 0;
        @(negedge clk);
        chk("fence_rd_req", rd_req, 1);
        chk("fence_rd_index", rd_index, 2);

        // Async reset mid-read with a queued command and an unacknowledged B.
        bready = 0;
        do_write(32'h3C, 32'hBEEF_0003, 4'hF, resp, got);
        chk("pre_rst_bvalid", bvalid, 1);
        chk("pre_rst_cmd_valid", cmd_valid, 1);
        chk("pre_rst_rd_req", rd_req, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_rd_req", rd_req, 0);
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_level", cmdq_level, 0);
        chk("midrst_cmd_data", cmd_data, 0);
        chk("midrst_rd_index", rd_index, 0);
        @(negedge clk) aresetn = 1'b1;
        @(negedge clk);
        chk("rerst_awready", awready, 1);
        chk("rerst_rd_req", rd_req, 0);

        @(posedge clk); #1 araddr = 32'h200; arvalid = 1; rready = 0;
        @(negedge clk);
        chk("rresp_arready", arready, 1);
        @(posedge clk); #1 arvalid = 0;
        repeat (3) @(negedge clk);
        chk("rresp_hold_rvalid", rvalid, 1);
        chk("rresp_hold_resp", rresp, 2'b10);
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rresp", rresp, 0);
        @(negedge clk) aresetn = 1'b1;
        @(negedge clk);
        chk("final_arready", arready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
